// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared FSM state type and destination-width helper for the demux scheduler
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int dest_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_sched_ctrl_if.sv
// rtl/demux_sched_ctrl_if.sv - source and per-channel sink handshake bundle of the demux scheduler
interface demux_sched_ctrl_if #(
  parameter int N_OUT  = 4,
  parameter int DEST_W = demux_pkg::dest_w(N_OUT)
);

  logic              in_valid;
  logic              in_data;
  logic [DEST_W-1:0] in_dest;
  logic              in_ready;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_data;
  logic [N_OUT-1:0]  out_ready;

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_1_n.sv
// rtl/demux_1_n.sv - combinational 1-to-N steering: y[sel] = i when en, all other bits 0
module demux_1_n #(
  parameter int N_OUT  = 4,
  parameter int DEST_W = 2
) (
  input  logic [DEST_W-1:0] sel,
  input  logic              i,
  input  logic              en,
  output logic [N_OUT-1:0]  y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (en && (sel == DEST_W'(k))) begin
        y[k] = i;
      end
    end
  end

endmodule

// File: rtl/demux_sched_ctrl.sv
// rtl/demux_sched_ctrl.sv - one-bit demux scheduler: addressed or round-robin routing with hold timeout
module demux_sched_ctrl
  import demux_pkg::*;
#(
  parameter int N_OUT   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  demux_sched_ctrl_if.slave   bus,
  output logic                busy,
  output logic                drop,
  output logic [7:0]          xfer_cnt
);

  localparam int DEST_W = dest_w(N_OUT);
  localparam logic [DEST_W:0] N_OUT_L = (DEST_W + 1)'(N_OUT);
  localparam logic [DEST_W-1:0] LAST_CH = DEST_W'(N_OUT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [DEST_W-1:0] dest_q, dest_nxt, rr_ptr, rr_nxt, rr_inc, cap_dest;
  logic              data_q, data_nxt, rr_q, rr_mode_nxt;
  logic [7:0]        wait_cnt, wait_nxt, xfer_nxt;
  logic              in_ready_q, accept, cap_legal, complete, timeout, drop_nxt;
  logic [N_OUT-1:0]  out_valid_q, out_data_q, valid_nxt, dval_nxt;

  assign accept    = in_ready_q && bus.in_valid;
  assign cap_dest  = mode ? rr_ptr : bus.in_dest;
  assign cap_legal = {1'b0, cap_dest} < N_OUT_L;
  assign rr_inc    = (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
  assign complete  = (state == HOLD) && bus.out_ready[dest_q];
  assign timeout   = (state == HOLD) && !bus.out_ready[dest_q] && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dest_q      <= '0;
      data_q      <= 1'b0;
      rr_q        <= 1'b0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      xfer_cnt    <= '0;
      in_ready_q  <= 1'b0;
      busy        <= 1'b0;
      drop        <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      dest_q      <= dest_nxt;
      data_q      <= data_nxt;
      rr_q        <= rr_mode_nxt;
      rr_ptr      <= rr_nxt;
      wait_cnt    <= wait_nxt;
      xfer_cnt    <= xfer_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      busy        <= (state_nxt == HOLD);
      drop        <= drop_nxt;
      out_valid_q <= valid_nxt;
      out_data_q  <= dval_nxt;
    end
  end

  // mode is latched with the bit so later toggles cannot change its routing or rr bookkeeping
  always_comb begin
    state_nxt   = state;
    dest_nxt    = dest_q;
    data_nxt    = data_q;
    rr_mode_nxt = rr_q;
    case (state)
      IDLE: begin
        if (accept && cap_legal) begin
          state_nxt   = HOLD;
          dest_nxt    = cap_dest;
          data_nxt    = bus.in_data;
          rr_mode_nxt = mode;
        end
      end
      HOLD: begin
        if (complete || timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wait_nxt = '0;
    xfer_nxt = xfer_cnt;
    rr_nxt   = rr_ptr;
    drop_nxt = 1'b0;
    case (state)
      IDLE: drop_nxt = accept && !cap_legal;
      HOLD: begin
        if (complete) begin
          xfer_nxt = xfer_cnt + 8'd1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
        drop_nxt = timeout;
        if ((complete || timeout) && rr_q) begin
          rr_nxt = rr_inc;
        end
      end
      default: drop_nxt = 1'b0;
    endcase
  end

  // steering is evaluated on next-state values so the registered outputs line up with HOLD
  demux_1_n #(.N_OUT(N_OUT), .DEST_W(DEST_W)) u_valid (
    .sel (dest_nxt),
    .i   (1'b1),
    .en  (state_nxt == HOLD),
    .y   (valid_nxt)
  );

  demux_1_n #(.N_OUT(N_OUT), .DEST_W(DEST_W)) u_data (
    .sel (dest_nxt),
    .i   (data_nxt),
    .en  (state_nxt == HOLD),
    .y   (dval_nxt)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
